// File: rtl/packet_planner_space_release_if.sv
// Planner <-> space-release bus: descriptor push, release pulses, pointer exchange.
interface packet_planner_space_release_if #(
  parameter int SPACE_GLB_PTR = 10,
  parameter int LEN_W         = 15,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_REL       = 4
);
  localparam int REL_W  = $clog2(MAX_REL + 1);
  localparam int PEND_W = $clog2(FIFO_DEPTH + 1);

  logic [SPACE_GLB_PTR-1:0] PKT_ADDR;
  logic [LEN_W-1:0]         PKT_LEN;
  logic                     PKT_VLD;
  logic                     PKT_RDY;
  logic [REL_W-1:0]         REL_CNT;
  logic                     REL_VLD;
  logic [SPACE_GLB_PTR-1:0] SPACE_GLB_WR_PTR;
  logic [SPACE_GLB_PTR-1:0] SPACE_GLB_RD_PTR;
  logic [PEND_W-1:0]        PEND_CNT;
  logic                     ERR;

  // planner / buffer-reader side
  modport master (
    output PKT_ADDR, PKT_LEN, PKT_VLD, REL_CNT, REL_VLD, SPACE_GLB_WR_PTR,
    input  PKT_RDY, SPACE_GLB_RD_PTR, PEND_CNT, ERR
  );

  // space-release block side
  modport slave (
    input  PKT_ADDR, PKT_LEN, PKT_VLD, REL_CNT, REL_VLD, SPACE_GLB_WR_PTR,
    output PKT_RDY, SPACE_GLB_RD_PTR, PEND_CNT, ERR
  );
endinterface

// File: rtl/packet_planner_space_release.sv
// Space release for the packet planner: queues block-granular packet end
// pointers and advances SPACE_GLB_RD_PTR one packet per cycle as the buffer
// reader reports in-order completions.
// Optional build macro: PACKET_PLANNER_REL_CHECK_EN enables the sticky ERR
// checker (pending overflow, popped END outside the free region).
module packet_planner_space_release #(
  parameter int SPACE_GLB_PTR = 10,
  parameter int BLOCK_SIZE    = 8,
  parameter int LEN_W         = 15,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_REL       = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  packet_planner_space_release_if.slave bus
);
  localparam int P      = SPACE_GLB_PTR;
  localparam int BLK_SH = $clog2(BLOCK_SIZE);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int RW     = $clog2(MAX_REL + 1);

  logic [P-1:0]     end_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [CW-1:0]    occ, occ_nxt;
  logic             rdy_q;
  logic [CW-1:0]    pend, pend_nxt;
  logic [CW:0]      pend_sum;
  logic             sat;
  logic [RW-1:0]    rel_add;
  logic [P-1:0]     rd_ptr;
  logic             push, pop;
  logic [LEN_W:0]   len_rnd, len_blk;
  logic [P-1:0]     pkt_end;

  // END pointer: round length up to whole blocks by add-then-shift
  always_comb begin
    len_rnd = {1'b0, bus.PKT_LEN} + (LEN_W+1)'(BLOCK_SIZE - 1);
    len_blk = len_rnd >> BLK_SH;
    pkt_end = bus.PKT_ADDR + P'(len_blk);
  end

  // handshake, pop decision and next-state arithmetic
  always_comb begin
    push     = bus.PKT_VLD & rdy_q;
    // pop only looks at registered occupancy, so a fresh push waits a cycle
    pop      = (pend != '0) & (occ != '0);
    rel_add  = bus.REL_VLD ? bus.REL_CNT : '0;
    pend_sum = (CW+1)'(pend) + (CW+1)'(rel_add) - (CW+1)'(pop);
    sat      = pend_sum > (CW+1)'(FIFO_DEPTH);
    pend_nxt = sat ? CW'(FIFO_DEPTH) : pend_sum[CW-1:0];
    occ_nxt  = occ + CW'(push) - CW'(pop);
  end

  // descriptor storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push) end_mem[wr_idx] <= pkt_end;
  end

  // FIFO pointers, pending count, registered ready and read pointer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
      rdy_q  <= 1'b0;
      pend   <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop) begin
        rd_idx <= rd_idx + 1'b1;
        rd_ptr <= end_mem[rd_idx];
      end
      occ   <= occ_nxt;
      rdy_q <= occ_nxt != CW'(FIFO_DEPTH);
      pend  <= pend_nxt;
    end
  end

  assign bus.PKT_RDY          = rdy_q;
  assign bus.SPACE_GLB_RD_PTR = rd_ptr;
  assign bus.PEND_CNT         = pend;

`ifdef PACKET_PLANNER_REL_CHECK_EN
  logic         err_q;
  logic [P-1:0] head_dist, free_dist;

  // ring distances from the current read pointer
  always_comb begin
    head_dist = end_mem[rd_idx] - rd_ptr;
    free_dist = bus.SPACE_GLB_WR_PTR - rd_ptr;
  end

  // sticky error: pending overflow or popped END past the write pointer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                     err_q <= 1'b0;
    else if (sat || (pop && head_dist > free_dist)) err_q <= 1'b1;
  end

  assign bus.ERR = err_q;
`else
  logic [P-1:0] unused_wr_ptr;
  assign unused_wr_ptr = bus.SPACE_GLB_WR_PTR;
  assign bus.ERR       = 1'b0;
`endif
endmodule

// File: tb/tb_packet_planner_space_release.sv
// Directed bench for packet_planner_space_release with a queue-based model
// checked every cycle plus literal expectations at the key cycles.
module tb_packet_planner_space_release;
  localparam int P     = 10;
  localparam int PMOD  = 1 << P;
  localparam int DEPTH = 16;
`ifdef PACKET_PLANNER_REL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  packet_planner_space_release_if #(
    .SPACE_GLB_PTR(P), .LEN_W(15), .FIFO_DEPTH(DEPTH), .MAX_REL(4)
  ) bus ();

  packet_planner_space_release #(
    .SPACE_GLB_PTR(P), .BLOCK_SIZE(8), .LEN_W(15), .FIFO_DEPTH(DEPTH), .MAX_REL(4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int m_q[$];
  int m_rd   = 0;
  int m_pend = 0;
  bit m_rdy  = 1'b0;
  bit m_err  = 1'b0;

  function automatic int end_of(int a, int l);
    return (a + (l + 7) / 8) % PMOD;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: apply release/pop/push rules at each clock edge
  always @(posedge CLK or posedge RESET) begin
    int add, np, e;
    bit pop;
    if (RESET) begin
      m_q.delete();
      m_rd = 0; m_pend = 0; m_rdy = 1'b0; m_err = 1'b0;
    end else begin
      add = bus.REL_VLD ? int'(bus.REL_CNT) : 0;
      pop = (m_pend > 0) && (m_q.size() > 0);
      np  = m_pend + add - (pop ? 1 : 0);
      if (np > DEPTH) begin
        np = DEPTH;
        if (CHECK) m_err = 1'b1;
      end
      if (pop) begin
        e = m_q.pop_front();
        if (CHECK && ((e - m_rd + PMOD) % PMOD) >
                     ((int'(bus.SPACE_GLB_WR_PTR) - m_rd + PMOD) % PMOD))
          m_err = 1'b1;
        m_rd = e;
      end
      if (bus.PKT_VLD && m_rdy) m_q.push_back(end_of(int'(bus.PKT_ADDR), int'(bus.PKT_LEN)));
      m_pend = np;
      m_rdy  = m_q.size() < DEPTH;
    end
  end

  // every-cycle comparison against the model
  always @(negedge CLK) begin
    chk("rd_ptr",   int'(bus.SPACE_GLB_RD_PTR), m_rd);
    chk("pend_cnt", int'(bus.PEND_CNT),         m_pend);
    chk("pkt_rdy",  int'(bus.PKT_RDY),          int'(m_rdy));
    chk("err",      int'(bus.ERR),              int'(m_err));
  end

  task automatic cyc(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(int a, int l);
    bus.PKT_ADDR         = P'(a);
    bus.PKT_LEN          = 15'(l);
    bus.PKT_VLD          = 1'b1;
    bus.SPACE_GLB_WR_PTR = P'(end_of(a, l));
    cyc();
    bus.PKT_VLD = 1'b0;
  endtask

  task automatic rel(int n);
    bus.REL_VLD = 1'b1;
    bus.REL_CNT = 3'(n);
    cyc();
    bus.REL_VLD = 1'b0;
    bus.REL_CNT = '0;
  endtask

  initial begin
    bus.PKT_ADDR = '0; bus.PKT_LEN = '0; bus.PKT_VLD = 1'b0;
    bus.REL_CNT  = '0; bus.REL_VLD = 1'b0; bus.SPACE_GLB_WR_PTR = '0;

    // reset state
    cyc(2);
    chk("rst_rd",   int'(bus.SPACE_GLB_RD_PTR), 0);
    chk("rst_pend", int'(bus.PEND_CNT), 0);
    chk("rst_rdy",  int'(bus.PKT_RDY), 0);
    chk("rst_err",  int'(bus.ERR), 0);
    RESET = 1'b0;
    cyc();
    chk("rdy_after_rst", int'(bus.PKT_RDY), 1);

    // single packet of 64 bytes -> 8 blocks
    push(0, 64);
    rel(1);
    chk("t1_pend_m1", int'(bus.PEND_CNT), 1);
    cyc();
    chk("t1_rd_m2",   int'(bus.SPACE_GLB_RD_PTR), 8);
    chk("t1_pend_m2", int'(bus.PEND_CNT), 0);

    // three packets released by one pulse drain on consecutive cycles
    push(0, 1); push(1, 9); push(3, 16);
    rel(3);
    chk("t2_pend3", int'(bus.PEND_CNT), 3);
    cyc(); chk("t2_rd1", int'(bus.SPACE_GLB_RD_PTR), 1); chk("t2_pend2", int'(bus.PEND_CNT), 2);
    cyc(); chk("t2_rd3", int'(bus.SPACE_GLB_RD_PTR), 3); chk("t2_pend1", int'(bus.PEND_CNT), 1);
    cyc(); chk("t2_rd5", int'(bus.SPACE_GLB_RD_PTR), 5); chk("t2_pend0", int'(bus.PEND_CNT), 0);

    // wrap: 1020 + 6 blocks = 2 mod 1024
    push(1020, 48);
    rel(1);
    cyc();
    chk("t3_wrap_rd", int'(bus.SPACE_GLB_RD_PTR), 2);

    // fill to 16, release one, then push concurrently with a pop
    for (int i = 0; i < DEPTH; i++) push(2 + i, 8);
    chk("t4_full_rdy", int'(bus.PKT_RDY), 0);
    rel(1);
    chk("t4_pop_cycle_rdy", int'(bus.PKT_RDY), 0);
    cyc();
    chk("t4_rdy_after_pop", int'(bus.PKT_RDY), 1);
    chk("t4_rd3", int'(bus.SPACE_GLB_RD_PTR), 3);
    rel(1);
    push(18, 8);
    chk("t4_pushpop_rdy", int'(bus.PKT_RDY), 1);
    chk("t4_pushpop_rd",  int'(bus.SPACE_GLB_RD_PTR), 4);
    push(19, 8);
    chk("t4_refull_rdy", int'(bus.PKT_RDY), 0);
    rel(4); rel(4); rel(4); rel(4);
    cyc(14);
    chk("t4_drain_rd",   int'(bus.SPACE_GLB_RD_PTR), 20);
    chk("t4_drain_pend", int'(bus.PEND_CNT), 0);
    chk("t4_drain_rdy",  int'(bus.PKT_RDY), 1);

    // pending with empty FIFO holds until descriptors arrive
    rel(2);
    cyc(3);
    chk("t5_hold_pend", int'(bus.PEND_CNT), 2);
    push(20, 8);
    chk("t5_nobypass_pend", int'(bus.PEND_CNT), 2);
    chk("t5_nobypass_rd",   int'(bus.SPACE_GLB_RD_PTR), 20);
    push(21, 16);
    chk("t5_pend1", int'(bus.PEND_CNT), 1);
    chk("t5_rd21",  int'(bus.SPACE_GLB_RD_PTR), 21);
    cyc();
    chk("t5_pend0", int'(bus.PEND_CNT), 0);
    chk("t5_rd23",  int'(bus.SPACE_GLB_RD_PTR), 23);

    // reset in the middle of a drain
    push(23, 8); push(24, 8); push(25, 8);
    rel(3);
    cyc();
    chk("t6_mid_rd", int'(bus.SPACE_GLB_RD_PTR), 24);
    RESET = 1'b1;
    #1;
    chk("t6_rst_rd",   int'(bus.SPACE_GLB_RD_PTR), 0);
    chk("t6_rst_pend", int'(bus.PEND_CNT), 0);
    chk("t6_rst_rdy",  int'(bus.PKT_RDY), 0);
    cyc(2);
    RESET = 1'b0;
    bus.SPACE_GLB_WR_PTR = '0;
    cyc();
    chk("t6_rdy_back", int'(bus.PKT_RDY), 1);

    // END beyond the write pointer
    push(0, 64);
    bus.SPACE_GLB_WR_PTR = P'(4);
    rel(1);
    cyc();
    chk("t7_rd8",  int'(bus.SPACE_GLB_RD_PTR), 8);
    chk("t7_err",  int'(bus.ERR), int'(CHECK));
    cyc(3);
    chk("t7_err_sticky", int'(bus.ERR), int'(CHECK));

    // pending saturates at FIFO depth with an empty FIFO
    rel(4); rel(4); rel(4); rel(4); rel(4);
    chk("t8_sat_pend", int'(bus.PEND_CNT), DEPTH);
    chk("t8_sat_err",  int'(bus.ERR), int'(CHECK));
    RESET = 1'b1;
    #1;
    chk("t8_rst_err",  int'(bus.ERR), 0);
    chk("t8_rst_pend", int'(bus.PEND_CNT), 0);
    cyc(2);
    RESET = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
